datapath_decode: RTL and testbench
==================================

# datapath_decode

Instruction-decode / register-read stage of the 5-stage 16-bit pipelined CPU. It consumes the IF_ID pipeline register produced by fetch, reads the 8×16 register file, sign-extends immediates, generates control, detects load-use hazards, and registers the result into ID_EX for execute. It also owns the register-file write port driven by writeback, and the stall/flush interaction with fetch.

## Interface
- NUM_REGS, 8, architectural registers r0–r7 (index 3 bits)
- IF_ID_WIDTH, 32 (definesPkg), input word width: [15:0] = PC+2, [31:16] = instruction
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- IF_ID  input  IF_ID_WIDTH  fetch pipeline register
- if_valid  input  1  IF_ID holds a real instruction
- flush  input  1  taken branch resolved in EX; squash this stage
- ex_valid, ex_mem_read  input  1 each  instruction currently in EX is valid / is a load
- ex_rd  input  3  destination register of EX instruction
- wb_en  input  1  writeback enable
- wb_rd  input  3  writeback register index
- wb_data  input  16  writeback value
- stall  output  1  combinational; drives fetch PCwrite low and holds IF_ID
- ID_EX  output  id_ex_t  registered pipeline register to execute

## Operation
- Decode fields: opcode = instr[4:0], rx = instr[7:5], ry = instr[10:8], imm8 = instr[15:8], imm11 = instr[15:5]; encodings are definesPkg constants.
- imm: imm8 or imm11 sign-extended to 16 bits per opcode class; mvhi places imm8 in [15:8], zero in [7:0].
- Control bits per opcode: reg_write, mem_read, mem_write, use_imm, is_branch, is_call (call writes PC+2 to r7, so rd = 7).
- Register read: rx_val = RF[rx], ry_val = RF[ry]. Write-before-read bypass: if wb_en and wb_rd equals the read index, the value is wb_data in the same cycle.
- RF write: on posedge when wb_en, RF[wb_rd] <= wb_data. All registers are writable, including r0.
- Load-use hazard: stall = if_valid & ex_valid & ex_mem_read & ((uses_rx & ex_rd==rx) | (uses_ry & ex_rd==ry)) & ~flush.
- ID_EX update each posedge:
  - reset: all zeros (valid=0).
  - flush: bubble.
  - stall: bubble.
  - otherwise: valid=if_valid, with decoded fields.
- A bubble has valid=0 and all control bits 0; data fields are don't-care but driven to 0.
- Flush has priority over stall. During a stall the upstream re-presents the same IF_ID next cycle; this stage keeps no copy.

## Timing
- Latency 1 cycle: IF_ID at edge N appears decoded in ID_EX at edge N+1.
- Load-use costs exactly one bubble. The next cycle the load is in MEM, so ex_mem_read from it is no longer visible, and stall drops.
- stall is purely combinational from IF_ID, ex_*, and flush; it has no registered state.
- Reset: ID_EX = 0, all RF entries = 0, stall = 0 while reset is high (ex_valid is 0 from downstream reset). Reset mid-stall drops the bubble and the stall in the same cycle.
- wb_en with flush or stall in the same cycle: the RF write still occurs.
- if_valid=0 produces ID_EX.valid=0 and never stalls.

## Structure
- definesPkg holds:
  - id_ex_t, a packed struct: valid, pc_plus2[15:0], rx_val, ry_val, imm[15:0], rx, ry, rd[2:0], opcode[4:0], reg_write, mem_read, mem_write, use_imm, is_branch, is_call.
  - ID_EX_WIDTH = $bits(id_ex_t).
  - The opcode localparams.
- One sub-module, regfile_8x16: two asynchronous read ports with write bypass and one synchronous write port; reset clears all entries.
- The decoder is a combinational always_comb case on opcode inside datapath_decode.

## Test plan
- Reset: hold reset 2 cycles. Expect ID_EX == 0, stall == 0, and reads of r0..r7 return 0.
- Write r3 = 0x1234 via wb, then decode add r1,r3. Expect ID_EX.ry_val == 0x1234, reg_write == 1, pc_plus2 matching IF_ID[15:0] one cycle later.
- Same-cycle bypass: wb_en with r2 = 0xBEEF while decoding mv r5,r2. Expect ry_val == 0xBEEF, not the stale value.
- Load-use: ex_valid = 1, ex_mem_read = 1, ex_rd = 4, instr add r0,r4. Expect stall = 1 and a bubble. With ex_mem_read = 0 on the next cycle, expect a valid decode.
- Flush with a concurrent hazard: flush = 1 plus load-use conditions. Expect stall = 0 and ID_EX.valid = 0.
- Immediate: mvi r1,#0xF0 gives imm 0xFFF0; mvhi #0x12 gives 0x1200; j with imm11 = 0x7FF gives 0xFFFF.

Source files
------------

// File: rtl/datapath_decode_pkg.sv
// rtl/datapath_decode_pkg.sv - shared types, widths and opcode encodings for the decode stage
package datapath_decode_pkg;

    localparam int NUM_REGS    = 8;
    localparam int REG_IDX_W   = 3;
    localparam int DATA_W      = 16;
    localparam int IF_ID_WIDTH = 32;

    // Opcode encodings (instr[4:0]); anything else decodes as a nop.
    localparam logic [4:0] OP_MV   = 5'h00;  // rx <= ry
    localparam logic [4:0] OP_ADD  = 5'h01;  // rx <= rx + ry
    localparam logic [4:0] OP_SUB  = 5'h02;  // rx <= rx - ry
    localparam logic [4:0] OP_AND  = 5'h03;  // rx <= rx & ry
    localparam logic [4:0] OP_MVI  = 5'h04;  // rx <= sext(imm8)
    localparam logic [4:0] OP_MVHI = 5'h05;  // rx[15:8] <= imm8, low byte kept
    localparam logic [4:0] OP_ADDI = 5'h06;  // rx <= rx + sext(imm8)
    localparam logic [4:0] OP_LD   = 5'h07;  // rx <= mem[ry]
    localparam logic [4:0] OP_ST   = 5'h08;  // mem[ry] <= rx
    localparam logic [4:0] OP_BZ   = 5'h09;  // if rx == 0: pc += sext(imm8)
    localparam logic [4:0] OP_J    = 5'h0A;  // pc += sext(imm11)
    localparam logic [4:0] OP_CALL = 5'h0B;  // r7 <= pc+2; pc += sext(imm11)
    localparam logic [4:0] OP_JR   = 5'h0C;  // pc <= rx

    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    pc_plus2;
        logic [DATA_W-1:0]    rx_val;
        logic [DATA_W-1:0]    ry_val;
        logic [DATA_W-1:0]    imm;
        logic [REG_IDX_W-1:0] rx;
        logic [REG_IDX_W-1:0] ry;
        logic [REG_IDX_W-1:0] rd;
        logic [4:0]           opcode;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 use_imm;
        logic                 is_branch;
        logic                 is_call;
    } id_ex_t;

    localparam int ID_EX_WIDTH = $bits(id_ex_t);

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

endpackage

// File: rtl/datapath_decode_if.sv
// rtl/datapath_decode_if.sv - fetch/execute/writeback-facing signal bundle of the decode stage
interface datapath_decode_if;
    import datapath_decode_pkg::*;

    logic [IF_ID_WIDTH-1:0] IF_ID;
    logic                   if_valid;
    logic                   flush;
    logic                   ex_valid;
    logic                   ex_mem_read;
    logic [REG_IDX_W-1:0]   ex_rd;
    logic                   wb_en;
    logic [REG_IDX_W-1:0]   wb_rd;
    logic [DATA_W-1:0]      wb_data;
    logic                   stall;
    id_ex_t                 ID_EX;

    // Surrounding pipeline side: drives fetch/EX/WB information, observes stall and ID_EX.
    modport master (
        output IF_ID, if_valid, flush, ex_valid, ex_mem_read, ex_rd,
               wb_en, wb_rd, wb_data,
        input  stall, ID_EX
    );

    // Decode stage side.
    modport slave (
        input  IF_ID, if_valid, flush, ex_valid, ex_mem_read, ex_rd,
               wb_en, wb_rd, wb_data,
        output stall, ID_EX
    );

endinterface

// File: rtl/datapath_decode_regfile.sv
// rtl/datapath_decode_regfile.sv - 8x16 register file, two async read ports with write bypass
module regfile_8x16
    import datapath_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rd_addr_a_i,
    output logic [DATA_W-1:0]    rd_data_a_o,
    input  logic [REG_IDX_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0]    rd_data_b_o,
    input  logic                 wr_en_i,
    input  logic [REG_IDX_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]    wr_data_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Storage: reset clears every entry; r0 is an ordinary writable register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read ports: a write landing this cycle is forwarded so decode never sees the stale value.
    always_comb begin
        rd_data_a_o = mem_q[rd_addr_a_i];
        rd_data_b_o = mem_q[rd_addr_b_i];
        if (wr_en_i && (wr_addr_i == rd_addr_a_i)) begin
            rd_data_a_o = wr_data_i;
        end
        if (wr_en_i && (wr_addr_i == rd_addr_b_i)) begin
            rd_data_b_o = wr_data_i;
        end
    end

endmodule

// File: rtl/datapath_decode.sv
// rtl/datapath_decode.sv - ID stage: field decode, register read, load-use stall, ID_EX register
module datapath_decode
    import datapath_decode_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    datapath_decode_if.slave bus
);

    logic [DATA_W-1:0]    instr;
    logic [DATA_W-1:0]    pc_plus2;
    logic [4:0]           opcode;
    logic [REG_IDX_W-1:0] rx_idx;
    logic [REG_IDX_W-1:0] ry_idx;
    logic [7:0]           imm8;
    logic [10:0]          imm11;
    logic [DATA_W-1:0]    rx_val;
    logic [DATA_W-1:0]    ry_val;

    logic                 reg_write_c;
    logic                 mem_read_c;
    logic                 mem_write_c;
    logic                 use_imm_c;
    logic                 is_branch_c;
    logic                 is_call_c;
    logic                 uses_rx_c;
    logic                 uses_ry_c;
    logic [DATA_W-1:0]    imm_c;
    logic [REG_IDX_W-1:0] rd_c;
    logic                 hazard;
    logic                 stall_c;

    id_ex_t               id_ex_d;
    id_ex_t               id_ex_q;

    assign pc_plus2 = bus.IF_ID[15:0];
    assign instr    = bus.IF_ID[31:16];
    assign opcode   = instr[4:0];
    assign rx_idx   = instr[7:5];
    assign ry_idx   = instr[10:8];
    assign imm8     = instr[15:8];
    assign imm11    = instr[15:5];

    regfile_8x16 u_regfile (
        .clk         (clk),
        .reset       (reset),
        .rd_addr_a_i (rx_idx),
        .rd_data_a_o (rx_val),
        .rd_addr_b_i (ry_idx),
        .rd_data_b_o (ry_val),
        .wr_en_i     (bus.wb_en),
        .wr_addr_i   (bus.wb_rd),
        .wr_data_i   (bus.wb_data)
    );

    // Opcode decode: control bits, which source registers are really consumed, and the immediate.
    always_comb begin
        reg_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        use_imm_c   = 1'b0;
        is_branch_c = 1'b0;
        is_call_c   = 1'b0;
        uses_rx_c   = 1'b0;
        uses_ry_c   = 1'b0;
        imm_c       = '0;
        rd_c        = rx_idx;
        case (opcode)
            OP_MV: begin
                reg_write_c = 1'b1;
                uses_ry_c   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
                reg_write_c = 1'b1;
                uses_rx_c   = 1'b1;
                uses_ry_c   = 1'b1;
            end
            OP_MVI: begin
                reg_write_c = 1'b1;
                use_imm_c   = 1'b1;
                imm_c       = sext8(imm8);
            end
            OP_MVHI: begin
                // EX merges the new high byte with the old low byte, so rx is a source.
                reg_write_c = 1'b1;
                use_imm_c   = 1'b1;
                uses_rx_c   = 1'b1;
                imm_c       = {imm8, 8'h00};
            end
            OP_ADDI: begin
                reg_write_c = 1'b1;
                use_imm_c   = 1'b1;
                uses_rx_c   = 1'b1;
                imm_c       = sext8(imm8);
            end
            OP_LD: begin
                reg_write_c = 1'b1;
                mem_read_c  = 1'b1;
                uses_ry_c   = 1'b1;
            end
            OP_ST: begin
                mem_write_c = 1'b1;
                uses_rx_c   = 1'b1;
                uses_ry_c   = 1'b1;
            end
            OP_BZ: begin
                is_branch_c = 1'b1;
                use_imm_c   = 1'b1;
                uses_rx_c   = 1'b1;
                imm_c       = sext8(imm8);
            end
            OP_J: begin
                is_branch_c = 1'b1;
                use_imm_c   = 1'b1;
                imm_c       = sext11(imm11);
            end
            OP_CALL: begin
                // Link register is fixed: PC+2 goes to r7.
                is_branch_c = 1'b1;
                is_call_c   = 1'b1;
                reg_write_c = 1'b1;
                use_imm_c   = 1'b1;
                imm_c       = sext11(imm11);
                rd_c        = 3'd7;
            end
            OP_JR: begin
                is_branch_c = 1'b1;
                uses_rx_c   = 1'b1;
            end
            default: begin
                rd_c = rx_idx;
            end
        endcase
    end

    // Load-use detection: the load in EX has no data yet, so hold fetch one cycle. A flush wins.
    always_comb begin
        hazard  = (uses_rx_c && (bus.ex_rd == rx_idx)) ||
                  (uses_ry_c && (bus.ex_rd == ry_idx));
        stall_c = bus.if_valid && bus.ex_valid && bus.ex_mem_read && hazard && !bus.flush;
    end

    assign bus.stall = stall_c;

    // Next ID_EX: a fully-zero bubble on flush, stall or an empty slot, otherwise the decode.
    always_comb begin
        id_ex_d = '0;
        if (bus.if_valid && !bus.flush && !stall_c) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.pc_plus2  = pc_plus2;
            id_ex_d.rx_val    = rx_val;
            id_ex_d.ry_val    = ry_val;
            id_ex_d.imm       = imm_c;
            id_ex_d.rx        = rx_idx;
            id_ex_d.ry        = ry_idx;
            id_ex_d.rd        = rd_c;
            id_ex_d.opcode    = opcode;
            id_ex_d.reg_write = reg_write_c;
            id_ex_d.mem_read  = mem_read_c;
            id_ex_d.mem_write = mem_write_c;
            id_ex_d.use_imm   = use_imm_c;
            id_ex_d.is_branch = is_branch_c;
            id_ex_d.is_call   = is_call_c;
        end
    end

    // ID_EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign bus.ID_EX = id_ex_q;

endmodule

// File: tb/tb_datapath_decode.sv
// tb/tb_datapath_decode.sv - randomized scoreboard bench for the decode stage
module tb_datapath_decode;
    import datapath_decode_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datapath_decode_if bus();

    datapath_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    id_ex_t        exp_q[$];
    logic [15:0]   rf[8];

    // ---------------- reference model ----------------
    function automatic logic reads_rx(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_MVHI, OP_ADDI, OP_ST, OP_BZ, OP_JR};
    endfunction

    function automatic logic reads_ry(input logic [4:0] op);
        return op inside {OP_MV, OP_ADD, OP_SUB, OP_AND, OP_LD, OP_ST};
    endfunction

    function automatic id_ex_t ref_decode(input logic [15:0] instr, input logic [15:0] pc,
                                          input logic [15:0] rxv, input logic [15:0] ryv);
        id_ex_t     e;
        logic [4:0] op;
        int         v;
        op = instr[4:0];
        e = '0;
        e.valid     = 1'b1;
        e.pc_plus2  = pc;
        e.rx        = instr[7:5];
        e.ry        = instr[10:8];
        e.rx_val    = rxv;
        e.ry_val    = ryv;
        e.opcode    = op;
        e.rd        = (op == OP_CALL) ? 3'd7 : instr[7:5];
        e.reg_write = op inside {OP_MV, OP_ADD, OP_SUB, OP_AND, OP_MVI, OP_MVHI, OP_ADDI, OP_LD, OP_CALL};
        e.mem_read  = (op == OP_LD);
        e.mem_write = (op == OP_ST);
        e.is_branch = op inside {OP_BZ, OP_J, OP_CALL, OP_JR};
        e.is_call   = (op == OP_CALL);
        e.use_imm   = op inside {OP_MVI, OP_MVHI, OP_ADDI, OP_BZ, OP_J, OP_CALL};
        if (op inside {OP_MVI, OP_ADDI, OP_BZ}) begin
            v = $signed(instr[15:8]);
            e.imm = v[15:0];
        end else if (op inside {OP_J, OP_CALL}) begin
            v = $signed(instr[15:5]);
            e.imm = v[15:0];
        end else if (op == OP_MVHI) begin
            v = instr[15:8] * 256;
            e.imm = v[15:0];
        end
        return e;
    endfunction

    function automatic logic [15:0] rf_read(input logic [2:0] idx);
        if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
        return rf[idx];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: model evaluates the held inputs mid-cycle, then the edge happens.
    task automatic cycle();
        logic [15:0] instr;
        logic [15:0] pc;
        logic [4:0]  op;
        logic        exp_stall;
        id_ex_t      e;
        @(negedge clk);
        instr = bus.IF_ID[31:16];
        pc    = bus.IF_ID[15:0];
        op    = instr[4:0];
        exp_stall = bus.if_valid && bus.ex_valid && bus.ex_mem_read && !bus.flush &&
                    ((reads_rx(op) && bus.ex_rd == instr[7:5]) ||
                     (reads_ry(op) && bus.ex_rd == instr[10:8]));
        chk("stall", {127'b0, bus.stall}, {127'b0, exp_stall});
        if (reset || bus.flush || exp_stall || !bus.if_valid) e = '0;
        else e = ref_decode(instr, pc, rf_read(instr[7:5]), rf_read(instr[10:8]));
        exp_q.push_back(e);
        if (reset) rf = '{default: '0};
        else if (bus.wb_en) rf[bus.wb_rd] = bus.wb_data;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        id_ex_t exp;
        #2;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (bus.ID_EX !== exp) begin
                bad++;
                $display("FAIL id_ex: got %h expected %h", bus.ID_EX, exp);
            end
        end
    end

    task automatic idle();
        bus.IF_ID = '0; bus.if_valid = 1'b0; bus.flush = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
        bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    endtask

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {5'b0, ry, rx, op};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rf = '{default: '0};
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        chk("reset_id_ex", {43'b0, bus.ID_EX}, 128'b0);
        reset = 1'b0;

        // every register reads zero after reset
        for (int i = 0; i < 8; i++) begin
            bus.IF_ID = {mk(OP_MV, 3'd0, 3'(i)), 16'h0100};
            bus.if_valid = 1'b1;
            cycle();
            chk("reset_rf", {112'b0, bus.ID_EX.ry_val}, 128'b0);
        end

        // write r3 then add r1,r3
        idle();
        bus.wb_en = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 16'h1234;
        cycle();
        idle();
        bus.IF_ID = {mk(OP_ADD, 3'd1, 3'd3), 16'h0042}; bus.if_valid = 1'b1;
        cycle();
        chk("add_ry_val", {112'b0, bus.ID_EX.ry_val}, {112'b0, 16'h1234});
        chk("add_reg_write", {127'b0, bus.ID_EX.reg_write}, 128'd1);
        chk("add_pc_plus2", {112'b0, bus.ID_EX.pc_plus2}, {112'b0, 16'h0042});

        // same-cycle bypass over a stale value
        idle();
        bus.wb_en = 1'b1; bus.wb_rd = 3'd2; bus.wb_data = 16'h1111;
        cycle();
        bus.wb_data = 16'hBEEF;
        bus.IF_ID = {mk(OP_MV, 3'd5, 3'd2), 16'h0044}; bus.if_valid = 1'b1;
        cycle();
        chk("bypass_ry_val", {112'b0, bus.ID_EX.ry_val}, {112'b0, 16'hBEEF});

        // load-use: one bubble, then a valid decode
        idle();
        bus.IF_ID = {mk(OP_ADD, 3'd0, 3'd4), 16'h0046}; bus.if_valid = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd4;
        #1;
        chk("loaduse_stall", {127'b0, bus.stall}, 128'd1);
        cycle();
        chk("loaduse_bubble", {127'b0, bus.ID_EX.valid}, 128'd0);
        bus.ex_mem_read = 1'b0;
        cycle();
        chk("loaduse_resume", {127'b0, bus.ID_EX.valid}, 128'd1);

        // flush overrides a concurrent hazard
        bus.ex_mem_read = 1'b1; bus.flush = 1'b1;
        #1;
        chk("flush_stall", {127'b0, bus.stall}, 128'd0);
        cycle();
        chk("flush_valid", {127'b0, bus.ID_EX.valid}, 128'd0);

        // immediates
        idle();
        bus.if_valid = 1'b1;
        bus.IF_ID = {8'hF0, 3'd1, OP_MVI, 16'h0050};
        cycle();
        chk("imm_mvi", {112'b0, bus.ID_EX.imm}, {112'b0, 16'hFFF0});
        bus.IF_ID = {8'h12, 3'd1, OP_MVHI, 16'h0052};
        cycle();
        chk("imm_mvhi", {112'b0, bus.ID_EX.imm}, {112'b0, 16'h1200});
        bus.IF_ID = {11'h7FF, OP_J, 16'h0054};
        cycle();
        chk("imm_j", {112'b0, bus.ID_EX.imm}, {112'b0, 16'hFFFF});

        // randomized traffic, including occasional resets in the middle of stalls
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] instr;
            instr = 16'($urandom);
            instr[4:0] = 5'($urandom_range(0, 15));
            bus.IF_ID       = {instr, 16'($urandom)};
            bus.if_valid    = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 7) == 0);
            bus.ex_valid    = ($urandom_range(0, 1) == 1);
            bus.ex_mem_read = ($urandom_range(0, 1) == 1);
            bus.ex_rd       = 3'($urandom);
            bus.wb_en       = ($urandom_range(0, 1) == 1);
            bus.wb_rd       = 3'($urandom);
            bus.wb_data     = 16'($urandom);
            reset           = ($urandom_range(0, 63) == 0);
            if (reset) bus.ex_valid = 1'b0;
            cycle();
        end
        reset = 1'b0;
        idle();

        repeat (2) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
